// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage F/D/X/M/W pipeline.
// Drives stage enables/flushes, EX forwarding selects and debug counters.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       d_rs,
    input  logic [4:0]       d_rt,
    input  logic             d_use_rs,
    input  logic             d_use_rt,
    input  logic [4:0]       x_rs,
    input  logic [4:0]       x_rt,
    input  logic [4:0]       x_rd,
    input  logic             x_regwrite,
    input  logic             x_memread,
    input  logic [4:0]       m_rd,
    input  logic             m_regwrite,
    input  logic [4:0]       w_rd,
    input  logic             w_regwrite,
    input  logic             x_redirect,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             fd_en,
    output logic             dx_en,
    output logic             xm_en,
    output logic             fd_flush,
    output logic             dx_flush,
    output logic             mw_flush,
    output logic             pc_redirect,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WW-1:0] WAIT_TOP = WW'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    logic lu, ms;
    logic [1:0] fa, fb;

    assign lu = x_memread && x_regwrite && (x_rd != 5'd0) &&
                ((d_use_rs && d_rs == x_rd) ||
                 (d_use_rt && d_rt == x_rd));
    assign ms = mem_req && !mem_ready;

    // M result is younger than W write data, so it wins.
    always_comb begin
        fa = 2'b00;
        fb = 2'b00;
        if (m_regwrite && m_rd != 5'd0 && m_rd == x_rs)
            fa = 2'b01;
        else if (w_regwrite && w_rd != 5'd0 && w_rd == x_rs)
            fa = 2'b10;
        if (m_regwrite && m_rd != 5'd0 && m_rd == x_rt)
            fb = 2'b01;
        else if (w_regwrite && w_rd != 5'd0 && w_rd == x_rt)
            fb = 2'b10;
    end

    always_comb begin
        state_d     = state_q;
        pc_en       = 1'b1;
        fd_en       = 1'b1;
        dx_en       = 1'b1;
        xm_en       = 1'b1;
        fd_flush    = 1'b0;
        dx_flush    = 1'b0;
        mw_flush    = 1'b0;
        pc_redirect = 1'b0;
        fwd_a       = fa;
        fwd_b       = fb;
        unique case (state_q)
            RUN: begin
                if (ms) begin
                    {pc_en, fd_en, dx_en, xm_en} = 4'b0000;
                    mw_flush = 1'b1;
                    state_d  = MEM_WAIT;
                end else if (x_redirect) begin
                    pc_redirect = 1'b1;
                    fd_flush    = 1'b1;
                    dx_flush    = 1'b1;
                end else if (lu) begin
                    pc_en    = 1'b0;
                    fd_en    = 1'b0;
                    dx_flush = 1'b1;
                    state_d  = LD_STALL;
                end
            end
            LD_STALL: begin
                if (ms) begin
                    {pc_en, fd_en, dx_en, xm_en} = 4'b0000;
                    mw_flush = 1'b1;
                    state_d  = MEM_WAIT;
                end else begin
                    state_d = RUN;
                end
            end
            MEM_WAIT: begin
                if (!mem_ready) begin
                    {pc_en, fd_en, dx_en, xm_en} = 4'b0000;
                    mw_flush = 1'b1;
                end else begin
                    state_d = RUN;
                    if (x_redirect) begin
                        pc_redirect = 1'b1;
                        fd_flush    = 1'b1;
                        dx_flush    = 1'b1;
                    end
                end
            end
            default: state_d = RUN;
        endcase
        // Hold every stage and fill with bubbles while in reset.
        if (!reset) begin
            {pc_en, fd_en, dx_en, xm_en} = 4'b0000;
            fd_flush    = 1'b1;
            dx_flush    = 1'b1;
            mw_flush    = 1'b1;
            pc_redirect = 1'b0;
            fwd_a       = 2'b00;
            fwd_b       = 2'b00;
        end
    end

    always_comb begin
        wait_d    = '0;
        timeout_d = timeout_q;
        if (state_q == MEM_WAIT && !mem_ready) begin
            if (wait_q == WAIT_TOP)
                timeout_d = 1'b1;
            else
                wait_d = wait_q + WW'(1);
            if (wait_q == WAIT_TOP)
                wait_d = wait_q;
        end
        stall_d = stall_q;
        flush_d = flush_q;
        if (!pc_en && stall_q != CNT_MAX)
            stall_d = stall_q + CNT_W'(1);
        if (pc_redirect && flush_q != CNT_MAX)
            flush_d = flush_q + CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= RUN;
            wait_q    <= '0;
            timeout_q <= 1'b0;
            stall_q   <= '0;
            flush_q   <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
        end
    end

    assign mem_timeout = timeout_q;
    assign stall_cnt   = stall_q;
    assign flush_cnt   = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: vector table, corner sequences and
// randomized cycles checked against a cycle-level pipeline model.
module tb_pipeline_hazard_ctrl;

    localparam int TMO   = 4;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic       rst_n;
        logic [4:0] d_rs;
        logic [4:0] d_rt;
        logic       d_use_rs;
        logic       d_use_rt;
        logic [4:0] x_rs;
        logic [4:0] x_rt;
        logic [4:0] x_rd;
        logic       x_regwrite;
        logic       x_memread;
        logic [4:0] m_rd;
        logic       m_regwrite;
        logic [4:0] w_rd;
        logic       w_regwrite;
        logic       x_redirect;
        logic       mem_req;
        logic       mem_ready;
    } in_t;

    typedef struct {
        in_t         in;
        logic [11:0] exp;
        string       name;
    } vec_t;

    localparam logic [11:0] O_RST  = 12'b0000_1110_0000;
    localparam logic [11:0] O_IDLE = 12'b1111_0000_0000;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    in_t cur;
    logic pc_en, fd_en, dx_en, xm_en;
    logic fd_flush, dx_flush, mw_flush, pc_redirect;
    logic [1:0] fwd_a, fwd_b;
    logic mem_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(cur.rst_n),
        .d_rs(cur.d_rs), .d_rt(cur.d_rt),
        .d_use_rs(cur.d_use_rs), .d_use_rt(cur.d_use_rt),
        .x_rs(cur.x_rs), .x_rt(cur.x_rt), .x_rd(cur.x_rd),
        .x_regwrite(cur.x_regwrite), .x_memread(cur.x_memread),
        .m_rd(cur.m_rd), .m_regwrite(cur.m_regwrite),
        .w_rd(cur.w_rd), .w_regwrite(cur.w_regwrite),
        .x_redirect(cur.x_redirect),
        .mem_req(cur.mem_req), .mem_ready(cur.mem_ready),
        .pc_en(pc_en), .fd_en(fd_en), .dx_en(dx_en), .xm_en(xm_en),
        .fd_flush(fd_flush), .dx_flush(dx_flush),
        .mw_flush(mw_flush), .pc_redirect(pc_redirect),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    int total = 0;
    int bad   = 0;

    // Model of what the pipeline is doing, not of the controller's encoding.
    bit m_waiting;
    bit m_bubble;
    int m_waited;
    bit m_to;
    int m_stall;
    int m_flush;

    task automatic check(input string n, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic in_t idle();
        in_t v = '0;
        v.rst_n = 1'b1;
        return v;
    endfunction

    function automatic logic [1:0] src_sel(input logic [4:0] src, input in_t v);
        logic [4:0] rd[2];
        logic       wr[2];
        logic [1:0] code[2];
        rd[0] = v.m_rd; wr[0] = v.m_regwrite; code[0] = 2'b01;
        rd[1] = v.w_rd; wr[1] = v.w_regwrite; code[1] = 2'b10;
        for (int i = 0; i < 2; i++)
            if (wr[i] && rd[i] != 0 && rd[i] == src) return code[i];
        return 2'b00;
    endfunction

    function automatic bit needs_load(input in_t v);
        if (!(v.x_memread && v.x_regwrite) || v.x_rd == 0) return 0;
        return (v.d_use_rs && v.d_rs == v.x_rd) ||
               (v.d_use_rt && v.d_rt == v.x_rd);
    endfunction

    function automatic logic [11:0] model_out(input in_t v);
        bit hold, redir, lu;
        logic [3:0] en;
        if (!v.rst_n) return O_RST;
        hold  = m_waiting ? !v.mem_ready : (v.mem_req && !v.mem_ready);
        redir = !hold && v.x_redirect && !m_bubble;
        lu    = !hold && !redir && !m_waiting && !m_bubble && needs_load(v);
        en    = hold ? 4'b0000 : (lu ? 4'b0011 : 4'b1111);
        return {en, redir, redir || lu, hold, redir,
                src_sel(v.x_rs, v), src_sel(v.x_rt, v)};
    endfunction

    task automatic model_step(input in_t v, input logic [11:0] o);
        bit frozen;
        if (!v.rst_n) begin
            m_waiting = 0; m_bubble = 0; m_waited = 0;
            m_to = 0; m_stall = 0; m_flush = 0;
            return;
        end
        frozen = o[5];
        if (frozen && !m_waiting) m_waited = 0;
        else if (frozen) begin
            m_waited++;
            if (m_waited >= TMO) m_to = 1;
        end
        if (!o[11] && m_stall < CMAX) m_stall++;
        if (o[4] && m_flush < CMAX) m_flush++;
        m_waiting = frozen;
        m_bubble  = !o[11] && !frozen;
    endtask

    task automatic step(input in_t v, output logic [11:0] got);
        logic [11:0] exp;
        cur = v;
        #4;
        exp = model_out(v);
        got = {pc_en, fd_en, dx_en, xm_en, fd_flush, dx_flush,
               mw_flush, pc_redirect, fwd_a, fwd_b};
        check("outs", 32'(got), 32'(exp));
        check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        check("flush_cnt", 32'(flush_cnt), 32'(m_flush));
        check("mem_timeout", 32'(mem_timeout), 32'(m_to));
        model_step(v, exp);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        logic [11:0] g;
        in_t v = idle();
        v.rst_n = 1'b0;
        step(v, g);
        check("reset_outs", 32'(g), 32'(O_RST));
    endtask

    vec_t tbl[$];

    task automatic add(input in_t v, input logic [11:0] e, input string n);
        vec_t t;
        t.in = v; t.exp = e; t.name = n;
        tbl.push_back(t);
    endtask

    in_t v, lu_v;
    logic [11:0] g;

    initial begin
        cur = idle();
        cur.rst_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        model_step(cur, O_RST);

        lu_v = idle();
        lu_v.x_memread = 1; lu_v.x_regwrite = 1; lu_v.x_rd = 8;
        lu_v.d_use_rs = 1; lu_v.d_rs = 8;

        add(idle(), O_IDLE, "idle");
        v = idle(); v.m_rd = 5; v.w_rd = 5; v.x_rs = 5;
        v.m_regwrite = 1; v.w_regwrite = 1;
        add(v, 12'b1111_0000_0100, "fwd_m_over_w");
        v.m_rd = 0; v.w_rd = 0; v.x_rs = 0;
        add(v, O_IDLE, "fwd_r0");
        v = idle(); v.w_rd = 7; v.w_regwrite = 1; v.x_rt = 7;
        add(v, 12'b1111_0000_0010, "fwd_b_w");
        v = idle(); v.m_rd = 5; v.m_regwrite = 1; v.x_rs = 5;
        v.w_rd = 6; v.w_regwrite = 1; v.x_rt = 6;
        add(v, 12'b1111_0000_0110, "fwd_ab_mix");
        add(lu_v, 12'b0011_0100_0000, "lu_rs");
        v = lu_v; v.d_use_rs = 0; v.d_use_rt = 1; v.d_rt = 8;
        add(v, 12'b0011_0100_0000, "lu_rt");
        v = lu_v; v.x_rd = 0; v.d_rs = 0;
        add(v, O_IDLE, "lu_r0");
        v = lu_v; v.d_use_rs = 0;
        add(v, O_IDLE, "lu_unused");
        v = lu_v; v.x_regwrite = 0;
        add(v, O_IDLE, "lu_no_wr");
        v = lu_v; v.x_redirect = 1;
        add(v, 12'b1111_1101_0000, "redir_over_lu");
        v = lu_v; v.mem_req = 1;
        add(v, 12'b0000_0010_0000, "ms_over_lu");
        v = idle(); v.mem_req = 1; v.mem_ready = 1;
        add(v, O_IDLE, "mem_same_cycle");

        foreach (tbl[i]) begin
            do_reset();
            step(tbl[i].in, g);
            check(tbl[i].name, 32'(g), 32'(tbl[i].exp));
        end

        // load-use: one stall cycle, then consumer forwarded from W
        do_reset();
        step(lu_v, g);
        check("lu_stall", 32'(g[11:10]), 32'(2'b00));
        step(lu_v, g);
        check("ldstall_free", 32'(g[11:8]), 32'(4'b1111));
        v = idle(); v.x_rs = 8; v.w_rd = 8; v.w_regwrite = 1;
        step(v, g);
        check("lu_fwd_w", 32'(g[3:2]), 32'(2'b10));
        check("lu_stall_cnt", 32'(stall_cnt), 32'd1);

        // redirect squashes the load-use consumer
        do_reset();
        v = lu_v; v.x_redirect = 1;
        step(v, g);
        step(idle(), g);
        check("no_ldstall", 32'(g[11:8]), 32'(4'b1111));
        check("redir_flush_cnt", 32'(flush_cnt), 32'd1);

        // mem wait: ready three cycles after the request
        do_reset();
        v = idle(); v.mem_req = 1;
        for (int i = 0; i < 3; i++) begin
            step(v, g);
            check("mw_freeze", 32'(g[11:5]), 32'(7'b0000_001));
        end
        v.mem_ready = 1;
        step(v, g);
        check("mw_release", 32'(g[11:5]), 32'(7'b1111_000));
        check("mw_stall_cnt", 32'(stall_cnt), 32'd3);

        // timeout, sticky across ready, cleared by reset mid-wait
        do_reset();
        v = idle(); v.mem_req = 1;
        for (int i = 0; i < 4; i++) step(v, g);
        check("to_early", 32'(mem_timeout), 32'd0);
        step(v, g);
        check("to_set", 32'(mem_timeout), 32'd1);
        step(v, g);
        step(v, g);
        v.mem_ready = 1;
        step(v, g);
        check("to_sticky", 32'(mem_timeout), 32'd1);
        v = idle(); v.mem_req = 1;
        step(v, g);
        step(v, g);
        do_reset();
        check("to_cleared", 32'(mem_timeout), 32'd0);
        step(idle(), g);
        check("rst_mw_clean", 32'(g), 32'(O_IDLE));

        // reset in LD_STALL leaves no residual stall
        do_reset();
        step(lu_v, g);
        do_reset();
        step(lu_v, g);
        check("rst_ld_lu_again", 32'(g[11:10]), 32'(2'b00));

        // saturation
        do_reset();
        v = idle(); v.mem_req = 1;
        for (int i = 0; i < 20; i++) step(v, g);
        check("stall_sat", 32'(stall_cnt), 32'(CMAX));
        do_reset();
        v = idle(); v.x_redirect = 1;
        for (int i = 0; i < 20; i++) step(v, g);
        check("flush_sat", 32'(flush_cnt), 32'(CMAX));

        // randomized traffic with occasional resets
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            v.rst_n      = ($urandom_range(0, 39) != 0);
            v.d_rs       = 5'($urandom_range(0, 3));
            v.d_rt       = 5'($urandom_range(0, 3));
            v.d_use_rs   = 1'($urandom);
            v.d_use_rt   = 1'($urandom);
            v.x_rs       = 5'($urandom_range(0, 3));
            v.x_rt       = 5'($urandom_range(0, 3));
            v.x_rd       = 5'($urandom_range(0, 3));
            v.x_regwrite = 1'($urandom);
            v.x_memread  = 1'($urandom);
            v.m_rd       = 5'($urandom_range(0, 3));
            v.m_regwrite = 1'($urandom);
            v.w_rd       = 5'($urandom_range(0, 3));
            v.w_regwrite = 1'($urandom);
            v.x_redirect = ($urandom_range(0, 5) == 0);
            v.mem_req    = ($urandom_range(0, 2) == 0);
            v.mem_ready  = ($urandom_range(0, 3) == 0);
            step(v, g);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Sequencing controller for the five-stage (F/D/X/M/W) MIPS processor pipeline. It generates per-stage register enables and flushes, EX-stage operand forwarding selects, load-use stalls, branch/jump flush on redirect, and a whole-pipeline freeze while a data-memory or serial access is outstanding. It sits beside the datapath and drives the FD/DX/XM/MW pipeline registers and the PC register. It also keeps saturating stall and flush counters for debug.

## Interface
- MEM_TIMEOUT, 64: MEM_WAIT cycles before `mem_timeout` is set.
- CNT_W, 16: width of the performance counters.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low.
- d_rs, d_rt  in  5 each  source registers of the instruction in D.
- d_use_rs, d_use_rt  in  1 each  D instruction reads rs / rt.
- x_rs, x_rt  in  5 each  source registers of the instruction in X.
- x_rd  in  5  destination register of the instruction in X.
- x_regwrite, x_memread  in  1 each  X instruction writes a register / is a load.
- m_rd  in  5  destination register of the instruction in M.
- m_regwrite  in  1  M instruction writes a register.
- w_rd  in  5  destination register of the instruction in W.
- w_regwrite  in  1  W instruction writes a register.
- x_redirect  in  1  taken branch, jump or jr/jalr resolved in X.
- mem_req  in  1  M stage issuing a load or store this cycle.
- mem_ready  in  1  data memory / serial port completes the access this cycle.
- pc_en, fd_en, dx_en, xm_en  out  1 each  register load enables.
- fd_flush, dx_flush, mw_flush  out  1 each  load a bubble (all control bits 0).
- pc_redirect  out  1  PC mux selects the redirect target.
- fwd_a, fwd_b  out  2 each  X operand select: 00 regfile, 01 M result, 10 W write data.
- mem_timeout  out  1  sticky flag.
- stall_cnt, flush_cnt  out  CNT_W each  saturating counters.

## Operation
- FSM states: RUN, LD_STALL, MEM_WAIT. Reset state is RUN.
- **Load-use hazard** (`lu`): x_memread & x_regwrite & x_rd≠0 & ((d_use_rs & d_rs==x_rd) | (d_use_rt & d_rt==x_rd)).
- **Memory stall** (`ms`): mem_req & !mem_ready.
- Priority in every state: ms > x_redirect > lu.
- **RUN:**
  - ms: all enables 0; mw_flush=1; go to MEM_WAIT.
  - x_redirect: all enables 1; pc_redirect=1; fd_flush=1; dx_flush=1; stay in RUN. Any lu is ignored because the D instruction is squashed.
  - lu: pc_en=0; fd_en=0; dx_flush=1; xm_en=1; go to LD_STALL.
  - Otherwise: all enables 1; no flushes.
- **LD_STALL:** X now holds a bubble. ms is handled as in RUN. Otherwise all enables 1 and return to RUN. x_redirect and lu cannot occur here; both are ignored.
- **MEM_WAIT:**
  - While !mem_ready: all enables 0; mw_flush=1; wait counter increments.
  - On mem_ready: all enables 1; mw_flush=0; go to RUN. A simultaneous x_redirect is honored in the same cycle.
- **Timeout:** when the wait counter reaches MEM_TIMEOUT-1 with no ready, mem_timeout is set. It stays set until reset, and the FSM keeps waiting. The wait counter clears on entry to MEM_WAIT.
- **Forwarding** (pure function of X/M/W inputs, independent of state): fwd_a=01 if m_regwrite & m_rd≠0 & m_rd==x_rs; else 10 if w_regwrite & w_rd≠0 & w_rd==x_rs; else 00. fwd_b is the same using x_rt. M has priority over W. Register 0 is never forwarded.
- **Counters:**
  - stall_cnt +1 on every cycle with pc_en=0.
  - flush_cnt +1 on every cycle with pc_redirect=1.
  - Both saturate at 2^CNT_W-1 and never wrap.

## Timing
- Enables, flushes, fwd and pc_redirect are combinational from the registered state and the current inputs (zero latency). State, counters and mem_timeout are registered.
- While reset=0: state=RUN; all enables 0; fd_flush=dx_flush=mw_flush=1; pc_redirect=0; fwd_a=fwd_b=00; mem_timeout=0; counters 0.
- A reset deasserted mid-MEM_WAIT or mid-LD_STALL returns to RUN with no residual stall.
- A load-use hazard costs exactly 1 cycle. A redirect costs 2 squashed instructions (F and D). A memory stall costs N cycles, where mem_ready arrives N cycles after mem_req.
- mem_ready in the same cycle as mem_req produces no stall.

## Test plan
- **Load-use:** lw $t0 in X, D reads $t0 → one cycle pc_en=fd_en=0, dx_flush=1; next cycle fwd_a=10 for the consumer; stall_cnt=1.
- **Forward priority:** m_rd=w_rd=x_rs=5, both regwrite → fwd_a=01. Same with x_rs=0 → fwd_a=00.
- **Redirect during lu:** x_redirect=1 and lu both true → pc_redirect=1, fd_flush=dx_flush=1, pc_en=1, no LD_STALL entry; flush_cnt=1.
- **Memory wait:** mem_req held, mem_ready asserted 3 cycles later → 3 freeze cycles with mw_flush=1, then all enables 1; stall_cnt=3.
- **Timeout:** MEM_TIMEOUT=4, no mem_ready for 6 cycles → mem_timeout=1 after 4 wait cycles and remains set after mem_ready; cleared only by reset=0.
- **Reset and saturation:** assert reset=0 in MEM_WAIT → next cycle all outputs at reset values. With CNT_W=4, run 20 stall cycles → stall_cnt=15.
